// File: rtl/alu_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_sched
// Purpose  : Round-robin sharing of one datapath ALU between ports A and B.
// Revision : 1.0
// ============================================================================
module alu_share_sched #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Port A
    input  logic              a_req_valid_i,
    output logic              a_req_ready_o,
    input  logic [1:0]        a_aluop_i,
    input  logic [5:0]        a_funct_i,
    input  logic [DATA_W-1:0] a_src1_i,
    input  logic [DATA_W-1:0] a_src2_i,
    input  logic [4:0]        a_shamt_i,
    output logic              a_rsp_valid_o,
    input  logic              a_rsp_ready_i,
    // Port B
    input  logic              b_req_valid_i,
    output logic              b_req_ready_o,
    input  logic [1:0]        b_aluop_i,
    input  logic [5:0]        b_funct_i,
    input  logic [DATA_W-1:0] b_src1_i,
    input  logic [DATA_W-1:0] b_src2_i,
    input  logic [4:0]        b_shamt_i,
    output logic              b_rsp_valid_o,
    input  logic              b_rsp_ready_i,
    // Shared response
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_err_o,
    // Shared ALU
    output logic [1:0]        alu_aluop_o,
    output logic [5:0]        alu_funct_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [4:0]        alu_shamt_o,
    input  logic [DATA_W-1:0] alu_result_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                owner_q, owner_d;
    logic [1:0]          aluop_q, aluop_d;
    logic [5:0]          funct_q, funct_d;
    logic [DATA_W-1:0]   src1_q, src1_d;
    logic [DATA_W-1:0]   src2_q, src2_d;
    logic [4:0]          shamt_q, shamt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;

    logic grant_a;
    logic grant_b;
    logic legal;
    logic owner_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prio_q   <= PORT_A;
            owner_q  <= PORT_A;
            aluop_q  <= '0;
            funct_q  <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            shamt_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            aluop_q  <= aluop_d;
            funct_q  <= funct_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            shamt_q  <= shamt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Ready is masked by rst so both readies read 0 while reset is held.
    always_comb begin
        grant_a       = a_req_valid_i & (~b_req_valid_i | (prio_q == PORT_A));
        grant_b       = b_req_valid_i & (~a_req_valid_i | (prio_q == PORT_B));
        a_req_ready_o = (state_q == S_IDLE) & grant_a & ~rst;
        b_req_ready_o = (state_q == S_IDLE) & grant_b & ~rst;
        a_rsp_valid_o = (state_q == S_RESP) & (owner_q == PORT_A);
        b_rsp_valid_o = (state_q == S_RESP) & (owner_q == PORT_B);
        owner_rsp_ready = (owner_q == PORT_A) ? a_rsp_ready_i : b_rsp_ready_i;

        unique case (aluop_q)
            2'b00, 2'b01: legal = 1'b1;
            2'b10:        legal = (funct_q == 6'b001011) || (funct_q == 6'b001101) ||
                                  (funct_q == 6'b010010) || (funct_q == 6'b100110);
            default:      legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        aluop_d  = aluop_q;
        funct_d  = funct_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        shamt_d  = shamt_q;
        result_d = result_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (a_req_ready_o) begin
                    aluop_d = a_aluop_i;
                    funct_d = a_funct_i;
                    src1_d  = a_src1_i;
                    src2_d  = a_src2_i;
                    shamt_d = a_shamt_i;
                    owner_d = PORT_A;
                    prio_d  = PORT_B;
                    state_d = S_EXEC;
                end else if (b_req_ready_o) begin
                    aluop_d = b_aluop_i;
                    funct_d = b_funct_i;
                    src1_d  = b_src1_i;
                    src2_d  = b_src2_i;
                    shamt_d = b_shamt_i;
                    owner_d = PORT_B;
                    prio_d  = PORT_A;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Unsupported encodings still reach the ALU; its output is dropped here.
                result_d = legal ? alu_result_i : '0;
                err_d    = ~legal;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (owner_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_result_o = result_q;
    assign rsp_err_o    = err_q;
    assign alu_aluop_o  = aluop_q;
    assign alu_funct_o  = funct_q;
    assign alu_src1_o   = src1_q;
    assign alu_src2_o   = src2_q;
    assign alu_shamt_o  = shamt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_sched
// Purpose  : Scoreboard bench for alu_share_sched with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_share_sched;

    logic        clk;
    logic        rst;
    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0]  a_aluop, b_aluop, alu_aluop;
    logic [5:0]  a_funct, b_funct, alu_funct;
    logic [31:0] a_src1, a_src2, b_src1, b_src2, alu_src1, alu_src2;
    logic [4:0]  a_shamt, b_shamt, alu_shamt;
    logic [31:0] rsp_result, alu_result;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    bit          exp_port[$];
    logic [31:0] exp_res[$];
    logic        exp_err[$];

    alu_share_sched #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid_i(a_req_valid), .a_req_ready_o(a_req_ready),
        .a_aluop_i(a_aluop), .a_funct_i(a_funct),
        .a_src1_i(a_src1), .a_src2_i(a_src2), .a_shamt_i(a_shamt),
        .a_rsp_valid_o(a_rsp_valid), .a_rsp_ready_i(a_rsp_ready),
        .b_req_valid_i(b_req_valid), .b_req_ready_o(b_req_ready),
        .b_aluop_i(b_aluop), .b_funct_i(b_funct),
        .b_src1_i(b_src1), .b_src2_i(b_src2), .b_shamt_i(b_shamt),
        .b_rsp_valid_o(b_rsp_valid), .b_rsp_ready_i(b_rsp_ready),
        .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .alu_aluop_o(alu_aluop), .alu_funct_o(alu_funct),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_shamt_o(alu_shamt),
        .alu_result_i(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unsupported encodings yield a marker the DUT must discard.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_aluop)
            2'b00: alu_result = alu_src1 - alu_src2;
            2'b01: alu_result = alu_src1 + alu_src2;
            2'b10: begin
                case (alu_funct)
                    6'b001011: alu_result = alu_src1 + alu_src2;
                    6'b001101: alu_result = alu_src1 - alu_src2;
                    6'b010010: alu_result = alu_src1 & alu_src2;
                    6'b100110: alu_result = alu_src2 << alu_shamt;
                    default:   alu_result = 32'hDEADBEEF;
                endcase
            end
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] res, input logic err);
        exp_port.push_back(port);
        exp_res.push_back(res);
        exp_err.push_back(err);
    endtask

    // Monitor: every response handshake is checked against the scoreboard head.
    bit          mon_p;
    logic [31:0] mon_r;
    logic        mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rsp_valid && b_rsp_valid)
                chk("rsp_valid_both", 32'd1, 32'd0);
            if ((a_rsp_valid && a_rsp_ready) || (b_rsp_valid && b_rsp_ready)) begin
                if (exp_port.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, b_rsp_valid}, 32'hFFFFFFFF);
                end else begin
                    mon_p = exp_port.pop_front();
                    mon_r = exp_res.pop_front();
                    mon_e = exp_err.pop_front();
                    chk("rsp_port", {31'd0, b_rsp_valid}, {31'd0, mon_p});
                    chk("rsp_result", rsp_result, mon_r);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e});
                end
            end
        end
    end

    task automatic wait_drain();
        int t = 0;
        while (exp_port.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_port.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_req(input bit port, input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] sh,
                          input logic [31:0] er, input logic ee);
        int t = 0;
        @(negedge clk);
        if (!port) begin
            a_aluop = op; a_funct = fn; a_src1 = s1; a_src2 = s2; a_shamt = sh; a_req_valid = 1'b1;
        end else begin
            b_aluop = op; b_funct = fn; b_src1 = s1; b_src2 = s2; b_shamt = sh; b_req_valid = 1'b1;
        end
        #1;
        while (!(port ? b_req_ready : a_req_ready) && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("req_accept_timeout", {31'd0, t >= 50}, 32'd0);
        push(port, er, ee);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    // Both ports valid continuously; grants must alternate starting with A.
    task automatic both_valid(input int n);
        bit ep = 1'b0;
        int ka = 0;
        int kb = 0;
        int t;
        @(negedge clk);
        a_aluop = 2'b01; a_funct = 6'd0; a_src1 = 32'd100; a_src2 = 32'd1; a_shamt = 5'd0;
        b_aluop = 2'b00; b_funct = 6'd0; b_src1 = 32'd50;  b_src2 = 32'd8; b_shamt = 5'd0;
        a_req_valid = 1'b1;
        b_req_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            #1;
            while (!(a_req_ready || b_req_ready) && t < 20) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("grant_port", {30'd0, a_req_ready, b_req_ready}, ep ? 32'd1 : 32'd2);
            if (a_req_ready) push(1'b0, 32'd101 + ka, 1'b0);
            else if (b_req_ready) push(1'b1, 32'd42 + kb, 1'b0);
            @(posedge clk);
            #1;
            if (!ep) begin ka++; a_src1 = 32'd100 + ka; end
            else     begin kb++; b_src1 = 32'd50 + kb; end
            ep = !ep;
            if (k == n - 1) begin
                a_req_valid = 1'b0;
                b_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  {30'd0, a_req_ready, b_req_ready}, 32'd0);
        chk({tag, "_rspv"},   {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
        chk({tag, "_alu_op"}, {19'd0, alu_aluop, alu_funct, alu_shamt}, 32'd0);
        chk({tag, "_src1"},   alu_src1, 32'd0);
        chk({tag, "_src2"},   alu_src2, 32'd0);
        chk({tag, "_result"}, rsp_result, 32'd0);
        chk({tag, "_err"},    {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_aluop = '0; a_funct = '0; a_src1 = '0; a_src2 = '0; a_shamt = '0;
        b_aluop = '0; b_funct = '0; b_src1 = '0; b_src2 = '0; b_shamt = '0;
        #1 rst = 1'b1;
        a_req_valid = 1'b1;
        #11;
        chk_all_zero("reset");
        a_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        both_valid(4);

        // Single A addu: ready in N, operands on ALU in N+1, response in N+2.
        @(negedge clk);
        a_aluop = 2'b10; a_funct = 6'b001011; a_src1 = 32'd5; a_src2 = 32'd7; a_shamt = 5'd0;
        a_req_valid = 1'b1;
        #1;
        chk("t1_ready_n", {30'd0, a_req_ready, b_req_ready}, 32'd2);
        push(1'b0, 32'd12, 1'b0);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        chk("t1_alu_funct", {26'd0, alu_funct}, 32'h0B);
        chk("t1_alu_src", {alu_src1[15:0], alu_src2[15:0]}, 32'h0005_0007);
        chk("t1_rspv_n1", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_rspv_n2", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd2);
        chk("t1_result_n2", rsp_result, 32'd12);
        wait_drain();

        // B sll with response backpressure; A waits and must not be granted.
        b_rsp_ready = 1'b0;
        do_req(1'b1, 2'b10, 6'b100110, 32'hFFFF, 32'h1, 5'd4, 32'h10, 1'b0);
        @(posedge clk);
        #1;
        a_aluop = 2'b01; a_funct = 6'd0; a_src1 = 32'd1; a_src2 = 32'd1; a_shamt = 5'd0;
        a_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'h10);
            chk("bp_req_ready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        a_req_valid = 1'b0;
        b_rsp_ready = 1'b1;
        wait_drain();

        // Unsupported encodings: error flag set and result forced to 0.
        do_req(1'b0, 2'b10, 6'b000000, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1);
        wait_drain();
        do_req(1'b0, 2'b11, 6'b001011, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1);
        wait_drain();

        // I-type sub and add.
        do_req(1'b0, 2'b00, 6'd0, 32'd9, 32'd4, 5'd0, 32'd5, 1'b0);
        wait_drain();
        do_req(1'b1, 2'b01, 6'd0, 32'd9, 32'd4, 5'd0, 32'd13, 1'b0);
        wait_drain();

        // Asynchronous reset in the middle of EXEC drops the transaction.
        @(negedge clk);
        a_aluop = 2'b01; a_funct = 6'd1; a_src1 = 32'd3; a_src2 = 32'd4; a_shamt = 5'd2;
        a_req_valid = 1'b1;
        #1;
        chk("rst_pre_ready", {30'd0, a_req_ready, b_req_ready}, 32'd2);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        chk("rst_pre_src1", alu_src1, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_rsp_pending", exp_port.size(), 32'd0);
        both_valid(2);

        chk("final_queue_empty", exp_port.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_sched.md
# alu_share_sched

Scheduler that shares the single datapath ALU between two requesters, port A and port B (e.g. the execute path and the branch/address path). It arbitrates requests round-robin and registers the winner's operands and ALUOp/funct onto the shared ALU inputs, where the ALU control decoder turns them into the internal ALU function. It captures the result one cycle later and returns it to the winner over a valid/ready response handshake. It also rejects encodings the ALU control decoder does not support.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- a_req_valid / b_req_valid  in  1  request present
- a_req_ready / b_req_ready  out  1  request accepted this cycle
- a_aluop / b_aluop  in  2  ALUOp: 10 R-type, 00 I-type sub, 01 I-type add
- a_funct / b_funct  in  6  instruction funct field (used only when ALUOp=10)
- a_src1, a_src2 / b_src1, b_src2  in  DATA_W  operands
- a_shamt / b_shamt  in  5  shift amount
- a_rsp_valid / b_rsp_valid  out  1  response present
- a_rsp_ready / b_rsp_ready  in  1  response consumed
- rsp_result  out  DATA_W  result, shared by both response ports
- rsp_err  out  1  unsupported encoding; result forced to 0
- alu_aluop  out  2  registered, to the ALU control decoder
- alu_funct  out  6  registered, to the ALU control decoder
- alu_src1, alu_src2  out  DATA_W  registered, to the ALU
- alu_shamt  out  5  registered, to the ALU
- alu_result  in  DATA_W  combinational ALU output

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant: if one valid, grant that port; if both valid, grant the port named by prio.
  - x_req_ready = (state==IDLE) & grant_x. It is combinational, and at most one ready is high.
  - On valid&ready: latch that port's aluop/funct/src1/src2/shamt into the alu_* registers, latch owner=A/B, set prio to the other port, go EXEC.
- EXEC (one cycle): capture rsp_result <= alu_result and compute rsp_err. Go RESP.
- Legal encodings:
  - ALUOp=10 with funct in {001011 addu, 001101 subu, 010010 and, 100110 sll}.
  - ALUOp=00.
  - ALUOp=01.
- Any other encoding (ALUOp=11, or ALUOp=10 with another funct): rsp_err=1, rsp_result=0. The request is still issued to the ALU, but the ALU output is discarded.
- RESP: owner_rsp_valid=1; the other port's rsp_valid=0. Hold rsp_result/rsp_err stable until owner_rsp_ready. On the handshake edge, go IDLE.
- prio changes only on a request accept, never while waiting.
- The alu_* registers hold their last value outside EXEC; they are not cleared.
- Reset, asynchronous at any time:
  - state=IDLE, prio=A, owner=A.
  - Every alu_* output=0, rsp_result=0, rsp_err=0, all ready/valid outputs=0.
  - An in-flight transaction is dropped with no response.

## Timing
- Cycle N: request handshake.
- N+1: EXEC; the alu_* outputs show the new operands.
- N+2: rsp_valid high (latency 2 cycles from accept).
- If rsp_ready is high in N+2, the next accept is at N+3 at the earliest. This gives a maximum throughput of one operation per 3 cycles.
- Response backpressure extends RESP indefinitely. While in RESP, neither req_ready is asserted.
- A request that arrives during EXEC/RESP waits. Requesters must hold valid and payload stable until ready.
- Simultaneous valids on consecutive transactions alternate A, B, A, ...

## Test plan
- A only, aluop=10, funct=001011, src1=5, src2=7. Expected: a_req_ready in cycle 0, alu_funct=001011 in cycle 1, a_rsp_valid in cycle 2 with rsp_result=12, rsp_err=0.
- A and B valid together for 4 transactions after reset. Expected: grants A, B, A, B; each rsp_valid appears only on the granted port.
- B aluop=10, funct=100110, src2=0x1, shamt=4, with b_rsp_ready low for 5 cycles. Expected: rsp_result=0x10 held stable, b_rsp_valid held high, no req_ready during the wait.
- A aluop=10, funct=000000, and then separately aluop=11. Expected: a_rsp_valid with rsp_err=1 and rsp_result=0 for each.
- Assert rst asynchronously mid-EXEC. Expected: all outputs 0 immediately, state IDLE, no response issued; the next request after reset is served normally with prio=A.
- I-type ops aluop=00 (src1=9, src2=4) and aluop=01 (src1=9, src2=4). Expected: rsp_result=5 and 13 respectively, rsp_err=0.
